// File: rtl/fcvt_int_issue.sv
// fcvt_int_issue: issue/writeback wrapper around a combinational int->fp converter.
// Requests are conditioned per opcode and queued. The FIFO head drives the converter,
// and the converted result is registered toward the FP writeback port.
// Optional feature macro: FCVT_NX_EN. When it is defined, an inexact flag is computed
// when an entry is written and then carried to rsp_nx. When it is undefined, rsp_nx is 0.
module fcvt_int_issue #(
    parameter int BUS_WIDTH = 64,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [BUS_WIDTH-1:0] req_data,
    input  logic [1:0]           req_op,
    input  logic [4:0]           req_rd,
    output logic [BUS_WIDTH-1:0] cvt_in,
    input  logic [BUS_WIDTH-1:0] cvt_fp,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BUS_WIDTH-1:0] rsp_data,
    output logic [4:0]           rsp_rd,
    output logic                 rsp_nx
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int MANT  = (BUS_WIDTH == 64) ? 52 : 23;
    localparam logic [BUS_WIDTH-1:0] ONE     = BUS_WIDTH'(1);
    // Adding this value to an IEEE word increments its exponent field by one.
    localparam logic [BUS_WIDTH-1:0] EXP_LSB = ONE << MANT;

    // FIFO storage
    logic [BUS_WIDTH-1:0] r_opnd_mem [DEPTH];
    logic [4:0]           r_rd_mem   [DEPTH];
    logic                 r_fix_mem  [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    // Output register
    logic                 r_rsp_valid;
    logic [BUS_WIDTH-1:0] r_rsp_data;
    logic [4:0]           r_rsp_rd;

    logic [BUS_WIDTH-1:0] w_cond;
    logic [BUS_WIDTH-1:0] w_store;
    logic                 w_fix;
    logic                 w_req_ready;
    logic                 w_push;
    logic                 w_load;
    logic                 w_head_fix;
    logic [BUS_WIDTH-1:0] w_fp_adj;

    // Operand conditioning. In the 32-bit build, L/LU behave like W/WU.
    generate
        if (BUS_WIDTH == 64) begin : g_cond64
            // Sign-extend or zero-extend the 32-bit ops, and pass 64-bit ops through.
            always_comb begin
                case (req_op)
                    2'b00:   w_cond = {{32{req_data[31]}}, req_data[31:0]};
                    2'b01:   w_cond = {32'h0000_0000, req_data[31:0]};
                    default: w_cond = req_data;
                endcase
            end
        end else begin : g_cond32
            // In the 32-bit datapath, the operand is used unchanged for every op.
            always_comb begin
                w_cond = req_data;
            end
        end
    endgenerate

    // An unsigned operand with its MSB set is stored halved.
    // The exponent is restored after conversion.
    always_comb begin
        w_fix = req_op[0] & w_cond[BUS_WIDTH-1];
        if (w_fix) begin
            w_store = {1'b0, w_cond[BUS_WIDTH-1:1]};
        end else begin
            w_store = w_cond;
        end
    end

`ifdef FCVT_NX_EN
    logic                 r_nx_mem [DEPTH];
    logic [BUS_WIDTH-1:0] w_mag;
    logic                 w_nx;
    logic                 r_rsp_nx;

    // Returns 1 when any bit below the retained mantissa of mag is set.
    function automatic logic calc_nx(input logic [BUS_WIDTH-1:0] mag);
        logic found;
        logic nx;
        found = 1'b0;
        nx    = 1'b0;
        for (int i = BUS_WIDTH - 1; i > MANT; i--) begin
            if (!found && mag[i]) begin
                found = 1'b1;
                nx    = |(mag & ((ONE << (i - MANT)) - ONE));
            end
        end
        return nx;
    endfunction

    // Compute the inexact flag from the stored magnitude and from the bit lost by the fix-up.
    always_comb begin
        if (w_store[BUS_WIDTH-1]) begin
            w_mag = ~w_store + ONE;
        end else begin
            w_mag = w_store;
        end
        w_nx = calc_nx(w_mag) | (w_fix & w_cond[0]);
    end

    // Per-entry inexact flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_nx_mem[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_nx_mem[r_wr_ptr] <= w_nx;
        end
    end

    // Registered inexact flag that travels with rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_nx <= 1'b0;
        end else if (w_load) begin
            r_rsp_nx <= r_nx_mem[r_rd_ptr];
        end
    end

    assign rsp_nx = r_rsp_nx;
`else
    assign rsp_nx = 1'b0;
`endif

    // Handshake qualifiers. The FIFO never accepts a push while it is full.
    always_comb begin
        w_req_ready = (r_count < CNT_W'(DEPTH)) && !flush;
        w_push      = req_valid && w_req_ready;
        w_load      = (r_count != {CNT_W{1'b0}}) && (!r_rsp_valid || rsp_ready) && !flush;
    end

    // The FIFO head feeds the converter. The fixed-up exponent is restored on its result.
    always_comb begin
        cvt_in     = r_opnd_mem[r_rd_ptr];
        w_head_fix = r_fix_mem[r_rd_ptr];
        if (w_head_fix) begin
            w_fp_adj = cvt_fp + EXP_LSB;
        end else begin
            w_fp_adj = cvt_fp;
        end
    end

    // FIFO payload write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_opnd_mem[i] <= {BUS_WIDTH{1'b0}};
                r_rd_mem[i]   <= 5'd0;
                r_fix_mem[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_opnd_mem[r_wr_ptr] <= w_store;
            r_rd_mem[r_wr_ptr]   <= req_rd;
            r_fix_mem[r_wr_ptr]  <= w_fix;
        end
    end

    // FIFO pointers. They wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output valid: set on load, and cleared on a consumed handshake or on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
        end else if (flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_load) begin
            r_rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // The output payload changes only on load, so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= {BUS_WIDTH{1'b0}};
            r_rsp_rd   <= 5'd0;
        end else if (w_load) begin
            r_rsp_data <= w_fp_adj;
            r_rsp_rd   <= r_rd_mem[r_rd_ptr];
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;

endmodule

// File: tb/tb_fcvt_int_issue.sv
// Self-checking bench for fcvt_int_issue (BUS_WIDTH=64, DEPTH=2).
// It provides a truncating int->fp converter model on cvt_in/cvt_fp.
// Expected results come from the semantic integer value of each request.
module tb_fcvt_int_issue;

    localparam int BW    = 64;
    localparam int DEPTH = 2;
`ifdef FCVT_NX_EN
    localparam logic NX_ON = 1'b1;
`else
    localparam logic NX_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [BW-1:0] req_data = 64'd0;
    logic [1:0]    req_op = 2'b00;
    logic [4:0]    req_rd = 5'd0;
    logic [BW-1:0] cvt_in;
    logic [BW-1:0] cvt_fp;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [BW-1:0] rsp_data;
    logic [4:0]    rsp_rd;
    logic          rsp_nx;

    int checks = 0;
    int errors = 0;

    fcvt_int_issue #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_op(req_op), .req_rd(req_rd),
        .cvt_in(cvt_in), .cvt_fp(cvt_fp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_nx(rsp_nx)
    );

    always #5 clk = ~clk;

    // Truncating conversion of (-1)^s * m to an IEEE double.
    function automatic logic [63:0] fp_trunc(input logic s, input logic [63:0] m);
        int k;
        logic [63:0] mant;
        if (m == 64'd0) return 64'd0;
        k = 0;
        for (int i = 0; i < 64; i++) if (m[i]) k = i;
        if (k >= 52) mant = m >> (k - 52);
        else         mant = m << (52 - k);
        return {s, 11'(1023 + k), mant[51:0]};
    endfunction

    // Inexact when the truncated value cannot be shifted back to m exactly.
    function automatic logic is_inexact(input logic [63:0] m);
        int k;
        logic [63:0] back;
        if (m == 64'd0) return 1'b0;
        k = 0;
        for (int i = 0; i < 64; i++) if (m[i]) k = i;
        if (k <= 52) return 1'b0;
        back = (m >> (k - 52)) << (k - 52);
        return back != m;
    endfunction

    // Converter model: reads cvt_in as a signed 64-bit integer.
    always_comb begin
        if (cvt_in[63]) cvt_fp = fp_trunc(1'b1, ~cvt_in + 64'd1);
        else            cvt_fp = fp_trunc(1'b0, cvt_in);
    end

    // Reference model, driven by the integer value the opcode denotes.
    task automatic ref_model(input logic [1:0] op, input logic [63:0] d,
                             output logic [63:0] e_data, output logic e_nx);
        logic        s;
        logic [63:0] m;
        logic [31:0] lo;
        lo = d[31:0];
        case (op)
            2'b00: begin s = lo[31]; m = s ? {32'd0, ~lo + 32'd1} : {32'd0, lo}; end
            2'b01: begin s = 1'b0;   m = {32'd0, lo}; end
            2'b10: begin s = d[63];  m = s ? ~d + 64'd1 : d; end
            default: begin s = 1'b0; m = d; end
        endcase
        e_data = fp_trunc(s, m);
        e_nx   = NX_ON & is_inexact(m);
    endtask

    // Send one request into an idle block with rsp_ready high, and observe its result.
    task automatic send_one(input logic [1:0] op, input logic [63:0] d, input logic [4:0] rd,
                            output logic [63:0] g_data, output logic [4:0] g_rd,
                            output logic g_nx, output logic acc_ok, output logic lat_ok);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_data = d; req_rd = rd; rsp_ready = 1'b1;
        #1 acc_ok = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        lat_ok = !rsp_valid;
        @(negedge clk);
        lat_ok = lat_ok && rsp_valid;
        g_data = rsp_data; g_rd = rsp_rd; g_nx = rsp_nx;
        @(negedge clk);
    endtask

    // Queue L 1, 2 and 3 with rsp_ready low. This leaves 1.0 held and two entries queued.
    task automatic fill_three();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b10; req_data = 64'(i); req_rd = 5'(10 + i);
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++; $display("FAIL fill_accept%0d: req_ready=%b required 1", i, req_ready);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: req_ready=%b rsp_valid=%b required 0/1", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 64'd0 || rsp_rd !== 5'd0 || rsp_nx !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h rd=%0d nx=%b required all zero",
                     rsp_valid, rsp_data, rsp_rd, rsp_nx);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [63:0] d;
        logic [4:0]  rd;
        logic [63:0] exp;
        logic        nx;
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        logic [63:0] g_data;
        logic [4:0]  g_rd;
        logic        g_nx, acc, lat;
        v[0] = '{2'b00, 64'h0000_0000_FFFF_FFFF, 5'd3,  64'hBFF0_0000_0000_0000, 1'b0};
        v[1] = '{2'b01, 64'h0000_0000_FFFF_FFFF, 5'd4,  64'h41EF_FFFF_FFE0_0000, 1'b0};
        v[2] = '{2'b11, 64'h8000_0000_0000_0000, 5'd5,  64'h43E0_0000_0000_0000, 1'b0};
        v[3] = '{2'b10, 64'h8000_0000_0000_0000, 5'd6,  64'hC3E0_0000_0000_0000, 1'b0};
        v[4] = '{2'b10, 64'h0020_0000_0000_0001, 5'd7,  64'h4340_0000_0000_0000, NX_ON};
        v[5] = '{2'b00, 64'hDEAD_BEEF_0000_0005, 5'd8,  64'h4014_0000_0000_0000, 1'b0};
        v[6] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,  64'h43EF_FFFF_FFFF_FFFF, NX_ON};
        v[7] = '{2'b10, 64'h0000_0000_0000_0000, 5'd31, 64'h0000_0000_0000_0000, 1'b0};
        v[8] = '{2'b01, 64'h0000_0000_8000_0000, 5'd1,  64'h41E0_0000_0000_0000, 1'b0};
        v[9] = '{2'b00, 64'h0000_0000_8000_0000, 5'd2,  64'hC1E0_0000_0000_0000, 1'b0};
        for (int i = 0; i < 10; i++) begin
            send_one(v[i].op, v[i].d, v[i].rd, g_data, g_rd, g_nx, acc, lat);
            checks++;
            if (!acc || !lat) begin
                errors++; $display("FAIL dir%0d_latency: accept=%b latency_ok=%b required 1/1", i, acc, lat);
            end
            checks++;
            if (g_data !== v[i].exp) begin
                errors++; $display("FAIL dir%0d_data: got %h required %h", i, g_data, v[i].exp);
            end
            checks++;
            if (g_rd !== v[i].rd || g_nx !== v[i].nx) begin
                errors++;
                $display("FAIL dir%0d_rd_nx: got rd=%0d nx=%b required rd=%0d nx=%b",
                         i, g_rd, g_nx, v[i].rd, v[i].nx);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] got_d[$];
        logic [4:0]  got_rd[$];
        int          got_c[$];
        logic [63:0] exp_d[4];
        logic        acc;
        exp_d[0] = 64'h3FF0_0000_0000_0000; exp_d[1] = 64'h4000_0000_0000_0000;
        exp_d[2] = 64'h4008_0000_0000_0000; exp_d[3] = 64'h4010_0000_0000_0000;
        fill_three();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_data = 64'd4; req_rd = 5'd14;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 1'b0 || rsp_data !== exp_d[0] || rsp_rd !== 5'd11) begin
                errors++;
                $display("FAIL bp_hold%0d: req_ready=%b data=%h rd=%0d required 0/%h/11",
                         i, req_ready, rsp_data, rsp_rd, exp_d[0]);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            acc = req_valid && req_ready;
            if (rsp_valid && rsp_ready) begin
                got_d.push_back(rsp_data); got_rd.push_back(rsp_rd); got_c.push_back(i);
            end
            @(negedge clk);
            if (acc) req_valid = 1'b0;
        end
        checks++;
        if (got_d.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d results required 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_rd[i] !== 5'(11 + i) || got_c[i] != i) begin
                    errors++;
                    $display("FAIL bp_result%0d: data=%h rd=%0d cycle=%0d required %h/%0d/%0d",
                             i, got_d[i], got_rd[i], got_c[i], exp_d[i], 11 + i, i);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] g_data;
        logic [4:0]  g_rd;
        logic        g_nx, acc, lat;
        fill_three();
        flush = 1'b1; req_valid = 1'b1; req_op = 2'b10; req_data = 64'd99; req_rd = 5'd20;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL flush_blocks_req: req_ready=%b required 0", req_ready);
        end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL flush_stale%0d: rsp_valid=%b required 0", i, rsp_valid);
            end
        end
        send_one(2'b10, 64'd7, 5'd21, g_data, g_rd, g_nx, acc, lat);
        checks++;
        if (!acc || !lat || g_data !== 64'h401C_0000_0000_0000 || g_rd !== 5'd21) begin
            errors++;
            $display("FAIL flush_resume: acc=%b lat=%b data=%h rd=%0d required 1/1/401c000000000000/21",
                     acc, lat, g_data, g_rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] g_data;
        logic [4:0]  g_rd;
        logic        g_nx, acc, lat;
        fill_three();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 64'd0 || rsp_rd !== 5'd0 || rsp_nx !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h rd=%0d nx=%b required all zero",
                     rsp_valid, rsp_data, rsp_rd, rsp_nx);
        end
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready: req_ready=%b required 1", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL reset_mid_stale%0d: rsp_valid=%b required 0", i, rsp_valid);
            end
        end
        send_one(2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 5'd22, g_data, g_rd, g_nx, acc, lat);
        checks++;
        if (!acc || !lat || g_data !== 64'hC008_0000_0000_0000 || g_rd !== 5'd22) begin
            errors++;
            $display("FAIL reset_mid_resume: acc=%b lat=%b data=%h rd=%0d required 1/1/c008000000000000/22",
                     acc, lat, g_data, g_rd);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        nx;
    } exp_t;

    task automatic test_random();
        exp_t exp_q[$];
        int   n_req = 300;
        fork
            begin : driver
                int sent = 0;
                int cyc = 0;
                exp_t e;
                while (sent < n_req && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    req_valid = ($urandom_range(0, 2) != 0);
                    req_op    = 2'($urandom_range(0, 3));
                    req_rd    = 5'($urandom_range(0, 31));
                    case ($urandom_range(0, 4))
                        0: req_data = {$urandom(), $urandom()};
                        1: req_data = 64'($urandom_range(0, 1000));
                        2: req_data = {1'b1, 31'($urandom()), $urandom()};
                        3: req_data = {$urandom(), 32'h0000_0000};
                        default: req_data = ~64'($urandom_range(0, 5));
                    endcase
                    #1;
                    if (req_valid && req_ready) begin
                        ref_model(req_op, req_data, e.data, e.nx);
                        e.rd = req_rd;
                        exp_q.push_back(e);
                        sent++;
                    end
                end
                @(negedge clk);
                req_valid = 1'b0;
            end
            begin : monitor
                int   rcv = 0;
                int   cyc = 0;
                logic prev_stall = 1'b0;
                logic [63:0] prev_d = 64'd0;
                logic [4:0]  prev_rd = 5'd0;
                exp_t e;
                while (rcv < n_req && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    if (prev_stall) begin
                        checks++;
                        if (rsp_valid !== 1'b1 || rsp_data !== prev_d || rsp_rd !== prev_rd) begin
                            errors++;
                            $display("FAIL rnd_stable: valid=%b data=%h rd=%0d required 1/%h/%0d",
                                     rsp_valid, rsp_data, rsp_rd, prev_d, prev_rd);
                        end
                    end
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (rsp_valid && rsp_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rnd_spurious: result %h with nothing expected", rsp_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (rsp_data !== e.data || rsp_rd !== e.rd || rsp_nx !== e.nx) begin
                                errors++;
                                $display("FAIL rnd_result%0d: data=%h rd=%0d nx=%b required %h/%0d/%b",
                                         rcv, rsp_data, rsp_rd, rsp_nx, e.data, e.rd, e.nx);
                            end
                        end
                        rcv++;
                    end
                    prev_stall = rsp_valid && !rsp_ready;
                    prev_d = rsp_data; prev_rd = rsp_rd;
                end
                checks++;
                if (rcv != n_req) begin
                    errors++; $display("FAIL rnd_timeout: received %0d required %0d", rcv, n_req);
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
